// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// The wait-state defaults are also used by the testbench.
package sram_ctrl_pkg;

  localparam int unsigned CntW = 4;

  localparam int unsigned DefRdWait  = 2;
  localparam int unsigned DefWrSetup = 1;
  localparam int unsigned DefWrPulse = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRdAccess,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StTurn
  } state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter used to time SRAM access phases; load has priority over enable.
// The count saturates at zero so that a stray enable cannot wrap it.
module wait_counter
  import sram_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Memory-side responder sequencing the enables of an external asynchronous SRAM.
// Every output is a flop; a TURN cycle after each read keeps the data bus from contending.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADR_W    = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RD_WAIT  = DefRdWait,
  parameter int unsigned WR_SETUP = DefWrSetup,
  parameter int unsigned WR_PULSE = DefWrPulse
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              req,
  input  logic              MemWrite,
  input  logic [ADR_W-1:0]  Adr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              ready,
  output logic              busy,
  output logic [ADR_W-1:0]  sram_adr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din
);

  localparam logic [CntW-1:0] RdLd    = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] SetupLd = CntW'(WR_SETUP - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(WR_PULSE - 1);

  state_t              state_d, state_q;
  logic [DATA_W-1:0]   rd_data_d, rd_data_q;
  logic [DATA_W-1:0]   dout_d, dout_q;
  logic [ADR_W-1:0]    adr_d, adr_q;
  logic                ready_d, ready_q;
  logic                busy_d, busy_q;
  logic                ce_n_d, ce_n_q;
  logic                oe_n_d, oe_n_q;
  logic                we_n_d, we_n_q;
  logic                doe_d, doe_q;

  logic                cnt_load;
  logic [CntW-1:0]     cnt_val;
  logic                cnt_en;
  logic                cnt_zero;

  wait_counter u_wait_counter (
    .clk_i      (clk1),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    dout_d    = dout_q;
    adr_d     = adr_q;
    ready_d   = 1'b0;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    doe_d     = doe_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          adr_d    = Adr;
          ce_n_d   = 1'b0;
          cnt_load = 1'b1;
          if (MemWrite) begin
            dout_d  = WrData;
            doe_d   = 1'b1;
            we_n_d  = 1'b1;
            cnt_val = SetupLd;
            state_d = StWrSetup;
          end else begin
            oe_n_d  = 1'b0;
            cnt_val = RdLd;
            state_d = StRdAccess;
          end
        end
      end
      StRdAccess: begin
        if (cnt_zero) begin
          rd_data_d = sram_din;
          ready_d   = 1'b1;
          oe_n_d    = 1'b1;
          ce_n_d    = 1'b1;
          state_d   = StTurn;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StWrSetup: begin
        if (cnt_zero) begin
          we_n_d   = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = PulseLd;
          state_d  = StWrPulse;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StWrPulse: begin
        if (cnt_zero) begin
          we_n_d  = 1'b1;
          ready_d = 1'b1;
          state_d = StWrHold;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StWrHold: begin
        ce_n_d  = 1'b1;
        doe_d   = 1'b0;
        state_d = StIdle;
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered so busy reflects the state without a decode after the flop.
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rd_data_q <= '0;
      dout_q    <= '0;
      adr_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      doe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      dout_q    <= dout_d;
      adr_q     <= adr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      doe_q     <= doe_d;
    end
  end

  assign RdData    = rd_data_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign sram_adr  = adr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a default-timing instance and a minimum-timing instance, each with an
// SRAM model, checked against a reference memory and latency arithmetic from the wait states.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        mem_write = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  adr_in = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] a_rd, a_dout, a_din, b_rd, b_dout, b_din;
  logic [7:0]  a_adr, b_adr;
  logic        a_ready, a_busy, a_ce_n, a_oe_n, a_we_n, a_doe;
  logic        b_ready, b_busy, b_ce_n, b_oe_n, b_we_n, b_doe;
  logic        req_a, req_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_rd [2];

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  sram_ctrl u_dut_a (
    .clk1(clk), .reset(rst_n), .req(req_a), .MemWrite(mem_write), .Adr(adr_in),
    .WrData(wr_data), .RdData(a_rd), .ready(a_ready), .busy(a_busy), .sram_adr(a_adr),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_dout(a_dout),
    .sram_doe(a_doe), .sram_din(a_din)
  );

  sram_ctrl #(.RD_WAIT(1), .WR_SETUP(1), .WR_PULSE(1)) u_dut_b (
    .clk1(clk), .reset(rst_n), .req(req_b), .MemWrite(mem_write), .Adr(adr_in),
    .WrData(wr_data), .RdData(b_rd), .ready(b_ready), .busy(b_busy), .sram_adr(b_adr),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_dout(b_dout),
    .sram_doe(b_doe), .sram_din(b_din)
  );

  // Asynchronous SRAM models: read data appears while selected and output-enabled.
  assign a_din = (!a_ce_n && !a_oe_n) ? mem_a[a_adr] : 16'hBAD0;
  assign b_din = (!b_ce_n && !b_oe_n) ? mem_b[b_adr] : 16'hBAD1;

  always @(negedge clk) begin
    if (!a_ce_n && !a_we_n && a_doe) mem_a[a_adr] <= a_dout;
    if (!b_ce_n && !b_we_n && b_doe) mem_b[b_adr] <= b_dout;
  end

  wire [15:0] o_rd   = sel ? b_rd   : a_rd;
  wire [7:0]  o_adr  = sel ? b_adr  : a_adr;
  wire [15:0] o_dout = sel ? b_dout : a_dout;
  wire o_ready = sel ? b_ready : a_ready;
  wire o_busy  = sel ? b_busy  : a_busy;
  wire o_ce_n  = sel ? b_ce_n  : a_ce_n;
  wire o_oe_n  = sel ? b_oe_n  : a_oe_n;
  wire o_we_n  = sel ? b_we_n  : a_we_n;
  wire o_doe   = sel ? b_doe   : a_doe;

  function automatic int exp_rd();
    return sel ? 1 : int'(DefRdWait);
  endfunction
  function automatic int exp_su();
    return sel ? 1 : int'(DefWrSetup);
  endfunction
  function automatic int exp_pw();
    return sel ? 1 : int'(DefWrPulse);
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (o_busy !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
  endtask

  // One request from IDLE, called at a negedge; optionally scrambles Adr after acceptance.
  task automatic run_txn(input logic we, input logic [7:0] adr, input logic [15:0] wd,
                         input bit chg_adr);
    int lat, we_lo, we_first, doe_cnt, extra_rdy, exp_lat, idx;
    bit adr_ok, post_ok;
    idx = sel ? 1 : 0;
    wait_idle();
    req = 1'b1; mem_write = we; adr_in = adr; wr_data = wd;
    lat = -1; we_lo = 0; we_first = -1; doe_cnt = 0; adr_ok = 1'b1;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (o_adr !== adr) adr_ok = 1'b0;
      if (o_we_n === 1'b0) begin
        we_lo++;
        if (we_first < 0) we_first = c;
      end
      if (o_doe === 1'b1) doe_cnt++;
      if (o_ready === 1'b1) begin
        lat = c;
        req = 1'b0;
      end else if (chg_adr) begin
        adr_in = 8'($urandom);
      end
    end
    exp_lat = we ? exp_su() + exp_pw() : exp_rd();
    n_checks++;
    if (lat !== exp_lat) $display("FAIL latency we=%0b adr=%h: got %0d want %0d", we, adr, lat,
                                  exp_lat);
    else n_pass++;
    n_checks++;
    if (adr_ok !== 1'b1) $display("FAIL sram_adr_stable adr=%h: got changed want %h", adr, adr);
    else n_pass++;
    if (we) begin
      n_checks++;
      if (we_first !== exp_su()) $display("FAIL we_n_fall: got %0d want %0d", we_first, exp_su());
      else n_pass++;
      n_checks++;
      if (we_lo !== exp_pw()) $display("FAIL we_n_width: got %0d want %0d", we_lo, exp_pw());
      else n_pass++;
      n_checks++;
      if (doe_cnt !== exp_su() + exp_pw() + 1)
        $display("FAIL doe_width: got %0d want %0d", doe_cnt, exp_su() + exp_pw() + 1);
      else n_pass++;
      n_checks++;
      if (o_rd !== last_rd[idx]) $display("FAIL rddata_kept: got %h want %h", o_rd, last_rd[idx]);
      else n_pass++;
      ref_mem[idx][adr] = wd;
    end else begin
      n_checks++;
      if (o_rd !== ref_mem[idx][adr])
        $display("FAIL read_data adr=%h: got %h want %h", adr, o_rd, ref_mem[idx][adr]);
      else n_pass++;
      last_rd[idx] = ref_mem[idx][adr];
    end
    extra_rdy = 0; post_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_ready === 1'b1) extra_rdy++;
      if (c == 0 && {o_ce_n, o_oe_n, o_we_n, o_doe, o_busy} !== 5'b11100) post_ok = 1'b0;
    end
    n_checks++;
    if (post_ok !== 1'b1) $display("FAIL post_idle: got ce/oe/we/doe/busy bad want 11100");
    else n_pass++;
    n_checks++;
    if (extra_rdy !== 0) $display("FAIL single_ready: got %0d extra want 0", extra_rdy);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_ce_n, a_oe_n, a_we_n, a_doe, a_ready, a_busy} !== 6'b111000)
      $display("FAIL reset_ctrl: got %b want 111000",
               {a_ce_n, a_oe_n, a_we_n, a_doe, a_ready, a_busy});
    else n_pass++;
    n_checks++;
    if ({a_rd, a_adr, a_dout} !== 40'd0)
      $display("FAIL reset_data: got %h want 0", {a_rd, a_adr, a_dout});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    sel = 1'b0;
    run_txn(1'b1, 8'h20, 16'h002D, 1'b0);
    run_txn(1'b0, 8'h20, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 16; i++)
      run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 16'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    int last_rdy, n_rdy, overlap, gap, exp_gap;
    bit cur_we, prev_doe, oel1, oel2;
    sel = 1'b0;
    wait_idle();
    cur_we = 1'b0; req = 1'b1; mem_write = 1'b0; adr_in = 8'h00; wr_data = 16'($urandom);
    last_rdy = -1; n_rdy = 0; overlap = 0; prev_doe = 1'b0; oel1 = 1'b0; oel2 = 1'b0;
    for (int c = 0; c < 80 && n_rdy < 6; c++) begin
      @(negedge clk);
      if (o_oe_n === 1'b0 && o_we_n === 1'b0) overlap++;
      if (o_doe === 1'b1 && !prev_doe) begin
        n_checks++;
        if ((!o_oe_n || oel1 || oel2) !== 1'b0)
          $display("FAIL turnaround c=%0d: got oe_n low near doe rise want separated", c);
        else n_pass++;
      end
      oel2 = oel1; oel1 = (o_oe_n === 1'b0); prev_doe = (o_doe === 1'b1);
      if (o_ready === 1'b1) begin
        gap = (last_rdy < 0) ? c : c - last_rdy;
        if (last_rdy < 0) exp_gap = exp_rd();
        else exp_gap = cur_we ? 2 + exp_su() + exp_pw() : 2 + exp_rd();
        n_checks++;
        if (gap !== exp_gap) $display("FAIL b2b_gap n=%0d: got %0d want %0d", n_rdy, gap, exp_gap);
        else n_pass++;
        if (cur_we) ref_mem[0][8'hFF] = wr_data;
        else begin
          n_checks++;
          if (o_rd !== ref_mem[0][8'h00])
            $display("FAIL b2b_read: got %h want %h", o_rd, ref_mem[0][8'h00]);
          else n_pass++;
          last_rd[0] = ref_mem[0][8'h00];
        end
        n_rdy++; last_rdy = c;
        cur_we = ~cur_we; mem_write = cur_we; adr_in = cur_we ? 8'hFF : 8'h00;
        wr_data = 16'($urandom);
        if (n_rdy == 6) req = 1'b0;
      end
    end
    req = 1'b0;
    n_checks++;
    if (n_rdy !== 6) $display("FAIL b2b_count: got %0d want 6", n_rdy);
    else n_pass++;
    n_checks++;
    if (overlap !== 0) $display("FAIL oe_we_overlap: got %0d want 0", overlap);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    sel = 1'b0;
    run_txn(1'b0, 8'h33, 16'h0000, 1'b1);
    run_txn(1'b1, 8'h34, 16'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid_write();
    int t = 0;
    sel = 1'b0;
    wait_idle();
    req = 1'b1; mem_write = 1'b1; adr_in = 8'hF0; wr_data = 16'hA5A5;
    while (o_we_n !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_we_n, o_ce_n, o_doe, o_busy, o_ready} !== 5'b11000)
      $display("FAIL reset_in_pulse: got %b want 11000", {o_we_n, o_ce_n, o_doe, o_busy, o_ready});
    else n_pass++;
    req = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_rd} !== 17'd0) $display("FAIL after_reset: got %h want 0", {o_busy, o_rd});
    else n_pass++;
    run_txn(1'b0, 8'h10, 16'h0000, 1'b0);
  endtask

  task automatic test_fast_params();
    logic [7:0] a;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom_range(0, 127));
      run_txn(1'b0, a, 16'h0000, 1'b0);
      run_txn(1'b1, a, 16'($urandom), 1'b0);
      run_txn(1'b0, a, 16'h0000, 1'b0);
    end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
      ref_mem[0][i] = mem_a[i];
      ref_mem[1][i] = mem_b[i];
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_write();
    test_fast_params();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
